seg_display_sequencer: RTL

Display controller that owns the LED bank and the four seven-segment digits and decides, cycle by cycle, what they show. It sits between the Nios II Avalon-MM bus, the 4-bit switch input and the display pins, sequencing four modes: CPU-driven, hex counter, scroll and blink. Switches are synchronized and debounced internally. The CPU can override the switch-selected mode through a control register.

---
 rtl/seg_display_sequencer_if.sv | 18 +
 rtl/seg_display_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg_display_sequencer_if.sv
// rtl/seg_display_sequencer_if.sv - Avalon-MM register bus between the CPU and the display sequencer
interface seg_display_sequencer_if;
    logic [1:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/seg_display_sequencer.sv
// rtl/seg_display_sequencer.sv - LED and four-digit seven-segment sequencer (CPU/count/scroll/blink)
// Switches are synchronized and debounced; the CPU may override the switch-selected mode.
module seg_display_sequencer #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int TICK_DIV     = 12_500_000,
    parameter int DEBOUNCE_CYC = 500_000
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    seg_display_sequencer_if.slave avs,
    input  logic [3:0]             switcher_in,
    output logic [7:0]             led_out,
    output logic [7:0]             seg1_out,
    output logic [7:0]             seg2_out,
    output logic [7:0]             seg3_out,
    output logic [7:0]             seg4_out
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        MODE_CPU    = 2'd0,
        MODE_COUNT  = 2'd1,
        MODE_SCROLL = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    if (CLK_HZ <= 0 || TICK_DIV < 2 || DEBOUNCE_CYC < 1) begin : g_param_check
        $error("seg_display_sequencer: illegal parameter value");
    end

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 8'hC0;  4'h1: hex7 = 8'hF9;  4'h2: hex7 = 8'hA4;  4'h3: hex7 = 8'hB0;
            4'h4: hex7 = 8'h99;  4'h5: hex7 = 8'h92;  4'h6: hex7 = 8'h82;  4'h7: hex7 = 8'hF8;
            4'h8: hex7 = 8'h80;  4'h9: hex7 = 8'h90;  4'hA: hex7 = 8'h88;  4'hB: hex7 = 8'h83;
            4'hC: hex7 = 8'hC6;  4'hD: hex7 = 8'hA1;  4'hE: hex7 = 8'h86;  default: hex7 = 8'h8E;
        endcase
    endfunction

    logic [3:0]         sw_meta_q, sw_sync_q, sw_deb_q, sw_deb_d;
    logic [3:0][DW-1:0] db_cnt_q, db_cnt_d;
    logic [31:0]        digits_q, digits_d;
    logic [7:0]         led_reg_q, led_reg_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [TW-1:0]      presc_q, presc_d;
    logic [1:0]         scroll_q, scroll_d;
    logic               phase_q, phase_d;
    mode_e              mode_prev_q, mode;
    logic [31:0]        seg_q, seg_d;
    logic [7:0]         led_q, led_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               mode_chg, pause, tick;

    assign mode     = ctrl_q[0] ? mode_e'(ctrl_q[2:1]) : mode_e'(sw_deb_q[1:0]);
    assign mode_chg = (mode != mode_prev_q);
    assign pause    = sw_deb_q[2];
    assign tick     = !mode_chg && !pause && (presc_q == TICK_LAST);

    // Each bit must disagree with its accepted value for DEBOUNCE_CYC consecutive cycles to flip.
    always_comb begin
        sw_deb_d = sw_deb_q;
        db_cnt_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (sw_sync_q[i] != sw_deb_q[i]) begin
                if (db_cnt_q[i] == DEB_LAST) sw_deb_d[i] = sw_sync_q[i];
                else                         db_cnt_d[i] = db_cnt_q[i] + DW'(1);
            end
        end
    end

    always_comb begin
        digits_d  = digits_q;
        led_reg_d = led_reg_q;
        ctrl_d    = ctrl_q;
        if (avs.avs_write) begin
            case (avs.avs_address)
                2'd0:    digits_d  = avs.avs_writedata;
                2'd1:    led_reg_d = avs.avs_writedata[7:0];
                2'd2:    ctrl_d    = avs.avs_writedata[2:0];
                default: ;
            endcase
        end
        rdata_d = rdata_q;
        if (avs.avs_read) begin
            case (avs.avs_address)
                2'd0:    rdata_d = digits_q;
                2'd1:    rdata_d = {24'h0, led_reg_q};
                2'd2:    rdata_d = {29'h0, ctrl_q};
                default: rdata_d = {cnt_q, 8'h00, sw_deb_q, 2'b00, mode};
            endcase
        end
    end

    // A mode change restarts the tick phase and the scroll/blink state; the counter survives it.
    always_comb begin
        presc_d  = presc_q;
        scroll_d = scroll_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        if (mode_chg) begin
            presc_d  = '0;
            scroll_d = '0;
            phase_d  = 1'b0;
        end else if (!pause) begin
            presc_d = (presc_q == TICK_LAST) ? '0 : presc_q + TW'(1);
        end
        if (tick) begin
            case (mode)
                MODE_COUNT:  cnt_d    = sw_deb_q[3] ? cnt_q - 16'd1 : cnt_q + 16'd1;
                MODE_SCROLL: scroll_d = scroll_q + 2'd1;
                MODE_BLINK:  phase_d  = ~phase_q;
                default:     ;
            endcase
        end
    end

    always_comb begin
        seg_d = digits_q;
        led_d = led_reg_q;
        case (mode)
            MODE_COUNT: begin
                seg_d = {hex7(cnt_q[15:12]), hex7(cnt_q[11:8]), hex7(cnt_q[7:4]), hex7(cnt_q[3:0])};
                led_d = cnt_q[7:0];
            end
            MODE_SCROLL: begin
                case (scroll_q)
                    2'd0: begin seg_d = digits_q;                          led_d = 8'h01; end
                    2'd1: begin seg_d = {digits_q[7:0],  digits_q[31:8]};  led_d = 8'h04; end
                    2'd2: begin seg_d = {digits_q[15:0], digits_q[31:16]}; led_d = 8'h10; end
                    default: begin seg_d = {digits_q[23:0], digits_q[31:24]}; led_d = 8'h40; end
                endcase
            end
            MODE_BLINK: begin
                if (phase_q) begin
                    seg_d = 32'hFFFF_FFFF;
                    led_d = 8'h00;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
            sw_deb_q    <= '0;
            db_cnt_q    <= '0;
            digits_q    <= 32'hFFFF_FFFF;
            led_reg_q   <= '0;
            ctrl_q      <= '0;
            cnt_q       <= '0;
            presc_q     <= '0;
            scroll_q    <= '0;
            phase_q     <= 1'b0;
            mode_prev_q <= MODE_CPU;
            seg_q       <= 32'hFFFF_FFFF;
            led_q       <= '0;
            rdata_q     <= '0;
        end else begin
            sw_meta_q   <= switcher_in;
            sw_sync_q   <= sw_meta_q;
            sw_deb_q    <= sw_deb_d;
            db_cnt_q    <= db_cnt_d;
            digits_q    <= digits_d;
            led_reg_q   <= led_reg_d;
            ctrl_q      <= ctrl_d;
            cnt_q       <= cnt_d;
            presc_q     <= presc_d;
            scroll_q    <= scroll_d;
            phase_q     <= phase_d;
            mode_prev_q <= mode;
            seg_q       <= seg_d;
            led_q       <= led_d;
            rdata_q     <= rdata_d;
        end
    end

    assign avs.avs_readdata = rdata_q;
    assign led_out  = led_q;
    assign seg1_out = seg_q[7:0];
    assign seg2_out = seg_q[15:8];
    assign seg3_out = seg_q[23:16];
    assign seg4_out = seg_q[31:24];
endmodule
